y86_inst_encoder: RTL and testbench

Sequential Y86-64 instruction encoder and program loader, the write-side counterpart of the instruction-fetch decoder. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake. It serialises the instruction into its byte-level encoding, with valC in little-endian order, and writes one byte per cycle into the byte-wide instruction memory write port at an auto-incrementing address. It is used by the bench and the boot loader to build ROM images in place.

---
 rtl/y86_inst_encoder.sv | 187 ++++++++++++++++++
 tb/tb_y86_inst_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_inst_encoder.sv
// Purpose: serialise one decoded Y86-64 instruction into byte writes at an auto-incrementing address.
// Latency: first byte one cycle after accept, one byte per cycle, inst_done with the last byte.
// Backpressure: in_ready drops while bytes are emitted and during an addr_load cycle; source holds fields.
module y86_inst_encoder #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_load,
  input  logic [63:0] addr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        inst_done,
  output logic        enc_err,
  output logic [63:0] next_addr
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;           // index of the byte currently on the write port
  logic [3:0]  len_q, len_d;
  logic [3:0]  ic_q, ic_d, fn_q, fn_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] next_addr_d, mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic        mem_we_d, inst_done_d, enc_err_d;

  logic [3:0]  acc_len;
  logic [64:0] end_addr;
  logic        acc_ok;
  logic [3:0]  k_nx;

  // Encoded length from icode; zero marks an unknown icode.
  function automatic logic [3:0] inst_len(input logic [3:0] ic);
    logic [3:0] l;
    l = 4'd0;
    case (ic)
      4'h0, 4'h1, 4'h9:         l = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:   l = 4'd2;
      4'h7, 4'h8:               l = 4'd9;
      4'h3, 4'h4, 4'h5:         l = 4'd10;
      default:                  l = 4'd0;
    endcase
    return l;
  endfunction

  function automatic logic ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    logic ok;
    case (ic)
      4'h2, 4'h7: ok = (fn <= 4'd6);
      4'h6:       ok = (fn <= 4'd3);
      default:    ok = (fn == 4'd0);
    endcase
    return ok;
  endfunction

  // Byte k of the encoding. valC index wraps in 3 bits, which is exact for
  // every reachable k (k-1 for 9-byte forms, k-2 for 10-byte forms).
  function automatic logic [7:0] byte_at(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc, input logic [3:0] len,
                                         input logic [3:0] k);
    logic [7:0] b;
    logic [2:0] idx;
    b   = {ic, fn};
    idx = 3'd0;
    if (k != 4'd0) begin
      if (len == 4'd9) begin
        idx = k[2:0] - 3'd1;
        b   = vc[{idx, 3'b000} +: 8];
      end else if (k == 4'd1) begin
        b = {ra, rb};
      end else begin
        idx = k[2:0] - 3'd2;
        b   = vc[{idx, 3'b000} +: 8];
      end
    end
    return b;
  endfunction

  assign acc_len  = inst_len(icode);
  // 65-bit sum so a pointer near the top of the address space cannot wrap.
  assign end_addr = {1'b0, next_addr} + {61'd0, acc_len};
  assign acc_ok   = (acc_len != 4'd0) && ifun_ok(icode, ifun) && (end_addr <= 65'(MEM_BYTES));
  assign in_ready = (state_q == IDLE) && !addr_load;
  assign k_nx     = k_q + 4'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    ic_d        = ic_q;
    fn_d        = fn_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    next_addr_d = next_addr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    inst_done_d = 1'b0;
    enc_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (addr_load) begin
          next_addr_d = addr_in;
        end else if (in_valid) begin
          if (!acc_ok) begin
            enc_err_d = 1'b1;
          end else begin
            state_d     = EMIT;
            k_d         = 4'd0;
            len_d       = acc_len;
            ic_d        = icode;
            fn_d        = ifun;
            ra_d        = rA;
            rb_d        = rB;
            valc_d      = valC;
            mem_we_d    = 1'b1;
            mem_addr_d  = next_addr;
            mem_wdata_d = {icode, ifun};
            inst_done_d = (acc_len == 4'd1);
          end
        end
      end
      EMIT: begin
        if (k_q == len_q - 4'd1) begin
          state_d     = IDLE;
          next_addr_d = next_addr + {60'd0, len_q};
        end else begin
          k_d         = k_nx;
          mem_we_d    = 1'b1;
          mem_addr_d  = next_addr + {60'd0, k_nx};
          mem_wdata_d = byte_at(ic_q, fn_q, ra_q, rb_q, valc_q, len_q, k_nx);
          inst_done_d = (k_q + 4'd2 == len_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= 4'd0;
      len_q     <= 4'd0;
      ic_q      <= 4'd0;
      fn_q      <= 4'd0;
      ra_q      <= 4'd0;
      rb_q      <= 4'd0;
      valc_q    <= 64'd0;
      next_addr <= 64'd0;
      mem_addr  <= 64'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      inst_done <= 1'b0;
      enc_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      ic_q      <= ic_d;
      fn_q      <= fn_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      next_addr <= next_addr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      inst_done <= inst_done_d;
      enc_err   <= enc_err_d;
    end
  end

endmodule

// File: tb/tb_y86_inst_encoder.sv
// Testbench for y86_inst_encoder: queue-based reference of expected byte writes per cycle.
// Outputs sampled on the falling edge; inputs driven right after sampling.
// Randomized instruction stream plus directed boundary cases.
module tb_y86_inst_encoder;
  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_load = 1'b0;
  logic [63:0] addr_in = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = 4'd0, ifun = 4'd0, rA = 4'd0, rB = 4'd0;
  logic [63:0] valC = 64'd0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        inst_done;
  logic        enc_err;
  logic [63:0] next_addr;

  always #5 clk = ~clk;

  y86_inst_encoder #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .addr_load(addr_load), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .inst_done(inst_done), .enc_err(enc_err),
    .next_addr(next_addr)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  data;
    logic        done;
    logic        err;
  } ev_t;

  ev_t         q[$];
  logic [63:0] ptr = 64'd0;
  logic [7:0]  mem [MEM];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive and predict.
  task automatic step(input logic al, input logic [63:0] ai, input logic v,
                      input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, output logic acc);
    ev_t        e;
    logic       busy;
    logic       legal;
    logic [3:0] maxf;
    logic [7:0] bq[$];
    @(negedge clk);
    chk("next_addr", next_addr, ptr);
    if (q.size() != 0) e = q.pop_front();
    else e = '0;
    chk("mem_we", mem_we, e.we);
    chk("inst_done", inst_done, e.done);
    chk("enc_err", enc_err, e.err);
    if (e.we) begin
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.data);
    end
    if (mem_we && mem_addr < 64'(MEM)) mem[mem_addr[9:0]] = mem_wdata;
    busy = e.we || (q.size() != 0);
    if (e.done) ptr = e.addr + 64'd1;
    addr_load = al; addr_in = ai; in_valid = v;
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    #1;
    chk("in_ready", in_ready, !busy && !al);
    acc = v && !busy && !al;
    if (!busy && al) ptr = ai;
    if (acc) begin
      bq.push_back({ic, fn});
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) bq.push_back({ra, rb});
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
        for (int i = 0; i < 8; i++) bq.push_back(vc[8*i +: 8]);
      maxf  = (ic == 4'h2 || ic == 4'h7) ? 4'd6 : (ic == 4'h6) ? 4'd3 : 4'd0;
      legal = (ic <= 4'hB) && (fn <= maxf) &&
              (({1'b0, ptr} + 65'(bq.size())) <= 65'd1024);
      if (!legal) begin
        e = '0; e.err = 1'b1; q.push_back(e);
      end else begin
        for (int i = 0; i < bq.size(); i++) begin
          e = '0; e.we = 1'b1; e.addr = ptr + 64'(i); e.data = bq[i];
          e.done = (i == bq.size() - 1);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 30 && !acc; n++) step(1'b0, 64'd0, 1'b1, ic, fn, ra, rb, vc, acc);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept within 30 cycles");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, acc);
  endtask

  task automatic load(input logic [63:0] a);
    logic acc;
    step(1'b1, a, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, acc);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) idle(1);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    idle(1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_we"}, mem_we, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_inst_done"}, inst_done, 64'd0);
    chk({tag, "_enc_err"}, enc_err, 64'd0);
    chk({tag, "_next_addr"}, next_addr, 64'd0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_mid");
    q.delete();
    ptr = 64'd0;
    in_valid = 1'b0; addr_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_mem(input int a, input logic [7:0] exp);
    chk($sformatf("mem[%0h]", a), mem[a], exp);
  endtask

  initial begin
    logic [7:0] irm [10];
    logic [7:0] jb  [9];
    logic [3:0] ic, fn;
    logic [3:0] vlist [10];
    for (int i = 0; i < MEM; i++) mem[i] = 8'd0;
    irm = '{8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    jb  = '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vlist = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};

    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // irmovq from address 0
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF);
    drain();
    for (int i = 0; i < 10; i++) check_mem(i, irm[i]);
    chk("irmovq_next_addr", next_addr, 64'd10);

    // addr_load then jmp
    load(64'h20);
    send(4'h7, 4'h0, 4'h0, 4'h0, 64'h100);
    drain();
    for (int i = 0; i < 9; i++) check_mem(32 + i, jb[i]);
    chk("jmp_next_addr", next_addr, 64'h29);

    // back-to-back short instructions
    load(64'd0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'd0);
    send(4'h6, 4'h0, 4'h3, 4'h1, 64'd0);
    drain();
    check_mem(0, 8'h00); check_mem(1, 8'h10); check_mem(2, 8'h90);
    check_mem(3, 8'h60); check_mem(4, 8'h31);
    chk("short_next_addr", next_addr, 64'd5);

    // illegal icode and illegal ifun
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
    send(4'h6, 4'h5, 4'h0, 4'h0, 64'd0);
    drain();
    chk("illegal_next_addr", next_addr, 64'd5);

    // memory-end boundary
    load(64'd1020);
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'd7);
    load(64'd1023);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain();
    check_mem(1023, 8'h10);
    chk("end_next_addr", next_addr, 64'd1024);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain();
    chk("end_overflow_next_addr", next_addr, 64'd1024);

    // reset while emitting the 4th byte of rmmovq
    load(64'd0);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h55);
    idle(3);
    reset_mid();
    check_mem(0, 8'h40); check_mem(1, 8'h12); check_mem(2, 8'h55);
    idle(1);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain();
    check_mem(0, 8'h10);
    chk("post_reset_next_addr", next_addr, 64'd1);

    // randomized stream
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ic = 4'($urandom_range(0, 15));
      else ic = vlist[$urandom_range(0, 9)];
      if ($urandom_range(0, 4) == 0) fn = 4'($urandom_range(0, 15));
      else if (ic == 4'h2 || ic == 4'h7 || ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else fn = 4'd0;
      send(ic, fn, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom});
      for (int g = 0, gn = $urandom_range(0, 2); g < gn; g++) begin
        if ($urandom_range(0, 5) == 0) load(64'($urandom_range(0, 1030)));
        else idle(1);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
